// File: rtl/seven_segment_scan.sv
// Multiplexed seven-segment driver: scans NUM_DIGITS digits over a shared segment bus,
// with double-buffered digit data that is only swapped in at a frame boundary.
module seven_segment_scan #(
  parameter int NUM_DIGITS     = 4,
  parameter int REFRESH_DIV    = 50000,
  parameter int HEX_MODE       = 0,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load,
  input  logic [4*NUM_DIGITS-1:0]   data_in,
  input  logic [NUM_DIGITS-1:0]     dp_in,
  input  logic                      en,
  output logic [6:0]                seg,
  output logic                      dp,
  output logic [NUM_DIGITS-1:0]     an,
  output logic                      frame_start
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DIV_W = $clog2(REFRESH_DIV);

  localparam logic [6:0]            SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic                  DP_OFF  = (SEG_ACTIVE_LOW != 0);
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = (AN_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}}
                                                                   : {NUM_DIGITS{1'b0}};

  logic [DIV_W-1:0]        div_cnt;
  logic [IDX_W-1:0]        digit_idx;
  logic [4*NUM_DIGITS-1:0] pend_data;
  logic [NUM_DIGITS-1:0]   pend_dp;
  logic                    pend_valid;
  logic [4*NUM_DIGITS-1:0] shown_data;
  logic [NUM_DIGITS-1:0]   shown_dp;
  logic                    wrapped;

  logic                    tick;
  logic                    last_digit;
  logic                    wrap;
  logic [3:0]              cur_code;
  logic                    cur_dp;
  logic [6:0]              cur_seg;
  logic [NUM_DIGITS-1:0]   sel;

  // Active-high segment patterns {a..g}; codes above 9 only light up in hex mode.
  function automatic logic [6:0] decode(input logic [3:0] code);
    case (code)
      4'h0:    decode = 7'b1111110;
      4'h1:    decode = 7'b0110000;
      4'h2:    decode = 7'b1101101;
      4'h3:    decode = 7'b1111001;
      4'h4:    decode = 7'b0110011;
      4'h5:    decode = 7'b1011011;
      4'h6:    decode = 7'b1011111;
      4'h7:    decode = 7'b1110000;
      4'h8:    decode = 7'b1111111;
      4'h9:    decode = 7'b1111011;
      4'hA:    decode = (HEX_MODE != 0) ? 7'b1110111 : 7'b0000000;
      4'hB:    decode = (HEX_MODE != 0) ? 7'b0011111 : 7'b0000000;
      4'hC:    decode = (HEX_MODE != 0) ? 7'b1001110 : 7'b0000000;
      4'hD:    decode = (HEX_MODE != 0) ? 7'b0111101 : 7'b0000000;
      4'hE:    decode = (HEX_MODE != 0) ? 7'b1001111 : 7'b0000000;
      default: decode = (HEX_MODE != 0) ? 7'b1000111 : 7'b0000000;
    endcase
  endfunction

  always_comb begin
    tick       = (div_cnt == DIV_W'(REFRESH_DIV - 1));
    last_digit = (digit_idx == IDX_W'(NUM_DIGITS - 1));
    wrap       = tick && last_digit;
    cur_code   = shown_data[{digit_idx, 2'b00} +: 4];
    cur_dp     = shown_dp[digit_idx];
    cur_seg    = decode(cur_code);
    sel        = NUM_DIGITS'(1) << digit_idx;
  end

  // frame_start lags the wrap by one extra register so it lines up with digit 0 on the pins.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt     <= '0;
      digit_idx   <= '0;
      pend_data   <= '0;
      pend_dp     <= '0;
      pend_valid  <= 1'b0;
      shown_data  <= '0;
      shown_dp    <= '0;
      wrapped     <= 1'b0;
      seg         <= SEG_OFF;
      dp          <= DP_OFF;
      an          <= AN_OFF;
      frame_start <= 1'b0;
    end else begin
      seg         <= (SEG_ACTIVE_LOW != 0) ? ~cur_seg : cur_seg;
      dp          <= (SEG_ACTIVE_LOW != 0) ? ~cur_dp : cur_dp;
      an          <= en ? ((AN_ACTIVE_LOW != 0) ? ~sel : sel) : AN_OFF;
      wrapped     <= wrap;
      frame_start <= wrapped;

      if (tick) begin
        div_cnt   <= '0;
        digit_idx <= last_digit ? '0 : digit_idx + IDX_W'(1);
      end else begin
        div_cnt   <= div_cnt + DIV_W'(1);
      end

      // A load coinciding with the wrap lands in pending and waits for the next frame.
      if (wrap && pend_valid) begin
        shown_data <= pend_data;
        shown_dp   <= pend_dp;
        pend_valid <= 1'b0;
      end
      if (load) begin
        pend_data  <= data_in;
        pend_dp    <= dp_in;
        pend_valid <= 1'b1;
      end
    end
  end

endmodule
